// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a sticky TRAP,
// driving datapath controls, PC/IR enables, memory handshakes and a retired-instruction counter.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_code,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_en,
    output logic        ALUSrc_A,
    output logic        ALUSrc_B,
    output logic        RegWrite,
    output logic        Branch,
    output logic [1:0]  PCSrc,
    output logic [3:0]  ALUControl,
    output logic [1:0]  MemtoReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        illegal_instr,
    output logic [31:0] instret
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LUI, C_AUIPC, C_JAL, C_JALR, C_B, C_LOAD, C_STORE
    } cls_t;

    state_t      state_q;
    cls_t        cls_q, cls_d;
    logic [3:0]  alu_q, alu_d;
    logic        legal_d;
    logic [31:0] instret_q;

    logic        imem_req_s, ir_load_s, pc_en_s, alu_a_s, alu_b_s, reg_write_s, branch_s;
    logic [1:0]  pc_src_s, mem_to_reg_s;
    logic [3:0]  alu_ctl_s;
    logic        dmem_req_s, dmem_we_s, illegal_s;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic        unused_fields_s;

    assign opcode_s        = instr_code[6:0];
    assign funct3_s        = instr_code[14:12];
    assign funct7_s        = instr_code[31:25];
    assign unused_fields_s = ^{instr_code[24:15], instr_code[11:7]};

    function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    // Instruction classification and ALU code, captured at the end of DECODE
    always_comb begin
        cls_d   = C_R;
        alu_d   = ALU_ADD;
        legal_d = 1'b1;
        case (opcode_s)
            OP_R: begin
                cls_d   = C_R;
                alu_d   = alu_map(funct3_s, funct7_s[5]);
                legal_d = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
            end
            OP_I: begin
                cls_d = C_I;
                alu_d = alu_map(funct3_s, (funct3_s == 3'b101) ? instr_code[30] : 1'b0);
            end
            OP_LUI:    cls_d = C_LUI;
            OP_AUIPC:  cls_d = C_AUIPC;
            OP_JAL:    cls_d = C_JAL;
            OP_JALR:   cls_d = C_JALR;
            OP_BRANCH: begin
                cls_d   = C_B;
                alu_d   = ALU_SUB;
                legal_d = (funct3_s != 3'b010) && (funct3_s != 3'b011);
            end
            OP_LOAD:   cls_d = C_LOAD;
            OP_STORE:  cls_d = C_STORE;
            default:   legal_d = 1'b0;
        endcase
    end

    // Sequencer state and registered decode fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= C_R;
            alu_q   <= ALU_ADD;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) state_q <= S_DECODE;
                    else            state_q <= S_FETCH;
                end
                S_DECODE: begin
                    cls_q   <= cls_d;
                    alu_q   <= alu_d;
                    state_q <= legal_d ? S_EXECUTE : S_TRAP;
                end
                S_EXECUTE: begin
                    if (cls_q == C_LOAD || cls_q == C_STORE) state_q <= S_MEM;
                    else                                     state_q <= S_FETCH;
                end
                S_MEM: begin
                    if (!dmem_ready)           state_q <= S_MEM;
                    else if (cls_q == C_STORE) state_q <= S_FETCH;
                    else                       state_q <= S_WB;
                end
                S_WB:    state_q <= S_FETCH;
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Control outputs per state; ir_load and the MEM exit follow the ready inputs
    always_comb begin
        imem_req_s   = 1'b0;
        ir_load_s    = 1'b0;
        pc_en_s      = 1'b0;
        alu_a_s      = 1'b0;
        alu_b_s      = 1'b0;
        reg_write_s  = 1'b0;
        branch_s     = 1'b0;
        pc_src_s     = 2'b00;
        alu_ctl_s    = ALU_ADD;
        mem_to_reg_s = 2'b00;
        dmem_req_s   = 1'b0;
        dmem_we_s    = 1'b0;
        illegal_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_s = 1'b1;
                ir_load_s  = imem_ready;
            end
            S_DECODE: begin
                imem_req_s = 1'b0;
            end
            S_EXECUTE: begin
                pc_en_s   = (cls_q != C_LOAD) && (cls_q != C_STORE);
                alu_ctl_s = alu_q;
                case (cls_q)
                    C_R:     reg_write_s = 1'b1;
                    C_I: begin
                        alu_b_s     = 1'b1;
                        reg_write_s = 1'b1;
                    end
                    C_LUI: begin
                        reg_write_s  = 1'b1;
                        mem_to_reg_s = 2'b11;
                    end
                    C_AUIPC: begin
                        alu_a_s     = 1'b1;
                        alu_b_s     = 1'b1;
                        reg_write_s = 1'b1;
                    end
                    C_JAL: begin
                        reg_write_s  = 1'b1;
                        mem_to_reg_s = 2'b10;
                        pc_src_s     = 2'b10;
                    end
                    C_JALR: begin
                        alu_b_s      = 1'b1;
                        reg_write_s  = 1'b1;
                        mem_to_reg_s = 2'b10;
                        pc_src_s     = 2'b11;
                    end
                    C_B: begin
                        branch_s = 1'b1;
                        pc_src_s = branch_taken ? 2'b01 : 2'b00;
                    end
                    C_LOAD, C_STORE: alu_b_s = 1'b1;
                    default:         alu_ctl_s = ALU_ADD;
                endcase
            end
            S_MEM: begin
                alu_b_s    = 1'b1;
                alu_ctl_s  = alu_q;
                dmem_req_s = 1'b1;
                dmem_we_s  = (cls_q == C_STORE);
                pc_en_s    = (cls_q == C_STORE) && dmem_ready;
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 2'b01;
                pc_en_s      = 1'b1;
            end
            S_TRAP:  illegal_s = 1'b1;
            default: illegal_s = 1'b0;
        endcase
    end

    // Reset forces every output low immediately, even though the state register sits in FETCH
    assign imem_req      = rst_n & imem_req_s;
    assign ir_load       = rst_n & ir_load_s;
    assign pc_en         = rst_n & pc_en_s;
    assign ALUSrc_A      = rst_n & alu_a_s;
    assign ALUSrc_B      = rst_n & alu_b_s;
    assign RegWrite      = rst_n & reg_write_s;
    assign Branch        = rst_n & branch_s;
    assign PCSrc         = rst_n ? pc_src_s : 2'b00;
    assign ALUControl    = rst_n ? alu_ctl_s : 4'd0;
    assign MemtoReg      = rst_n ? mem_to_reg_s : 2'b00;
    assign dmem_req      = rst_n & dmem_req_s;
    assign dmem_we       = rst_n & dmem_we_s;
    assign illegal_instr = rst_n & illegal_s;

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       instret_q <= 32'd0;
        else if (pc_en_s) instret_q <= instret_q + 32'd1;
        else              instret_q <= instret_q;
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: per-instruction expected cycle
// sequences are built from the instruction-level rules and compared every cycle.
module tb_multicycle_ctrl;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4;
    localparam logic [3:0] A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8, A_AND = 4'd9;

    typedef struct packed {
        logic       imem_req, ir_load, pc_en, alu_a, alu_b, reg_write, branch;
        logic [1:0] pc_src;
        logic [3:0] alu_ctl;
        logic [1:0] mem_to_reg;
        logic       dmem_req, dmem_we, illegal;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_code = 32'd0;
    logic        branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        imem_req, ir_load, pc_en, ALUSrc_A, ALUSrc_B, RegWrite, Branch;
    logic [1:0]  PCSrc, MemtoReg;
    logic [3:0]  ALUControl;
    logic        dmem_req, dmem_we, illegal_instr;
    logic [31:0] instret;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_instret = 32'd0;
    ctl_t        act_s, last_act, exec_seen;
    int          ncyc;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_code(instr_code), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_load(ir_load),
        .pc_en(pc_en), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .RegWrite(RegWrite),
        .Branch(Branch), .PCSrc(PCSrc), .ALUControl(ALUControl), .MemtoReg(MemtoReg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .illegal_instr(illegal_instr), .instret(instret)
    );

    assign act_s = {imem_req, ir_load, pc_en, ALUSrc_A, ALUSrc_B, RegWrite, Branch,
                    PCSrc, ALUControl, MemtoReg, dmem_req, dmem_we, illegal_instr};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge with inputs already applied; checks just before the rising edge.
    task automatic do_cycle(input ctl_t e, input string name);
        #3;
        chk(name, {14'd0, act_s}, {14'd0, e});
        chk({name, "_instret"}, instret, model_instret);
        last_act = act_s;
        if (e.pc_en) model_instret = model_instret + 32'd1;
        @(negedge clk);
    endtask

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? A_SUB : A_ADD;
            3'd1:    return A_SLL;
            3'd2:    return A_SLT;
            3'd3:    return A_SLTU;
            3'd4:    return A_XOR;
            3'd5:    return alt ? A_SRA : A_SRL;
            3'd6:    return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic bit is_legal(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011: return (ins[31:25] == 7'd0) || (ins[31:25] == 7'b0100000);
            7'b1100011: return (ins[14:12] != 3'd2) && (ins[14:12] != 3'd3);
            7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b0000011, 7'b0100011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctl_t exec_model(input logic [31:0] ins, input bit taken);
        ctl_t       e  = '0;
        logic [2:0] f3 = ins[14:12];
        e.pc_en = 1'b1;
        case (ins[6:0])
            7'b0110011: begin e.alu_ctl = alu_of(f3, ins[30]); e.reg_write = 1'b1; end
            7'b0010011: begin
                e.alu_b = 1'b1; e.reg_write = 1'b1;
                e.alu_ctl = alu_of(f3, (f3 == 3'd5) ? ins[30] : 1'b0);
            end
            7'b0110111: begin e.reg_write = 1'b1; e.mem_to_reg = 2'b11; end
            7'b0010111: begin e.alu_a = 1'b1; e.alu_b = 1'b1; e.reg_write = 1'b1; end
            7'b1101111: begin e.reg_write = 1'b1; e.mem_to_reg = 2'b10; e.pc_src = 2'b10; end
            7'b1100111: begin
                e.alu_b = 1'b1; e.reg_write = 1'b1; e.mem_to_reg = 2'b10; e.pc_src = 2'b11;
            end
            7'b1100011: begin
                e.branch = 1'b1; e.alu_ctl = A_SUB; e.pc_src = taken ? 2'b01 : 2'b00;
            end
            7'b0000011, 7'b0100011: begin e.alu_b = 1'b1; e.pc_en = 1'b0; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic ctl_t mem_model(input bit st);
        ctl_t e = '0;
        e.alu_b = 1'b1; e.alu_ctl = A_ADD; e.dmem_req = 1'b1; e.dmem_we = st;
        return e;
    endfunction

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input bit taken, input bit abort_mem, output int cyc);
        ctl_t e;
        bit   st;
        cyc = 0;
        for (int i = 0; i < fw; i++) begin
            imem_ready = 1'b0; dmem_ready = 1'($urandom); branch_taken = 1'($urandom);
            e = '0; e.imem_req = 1'b1;
            do_cycle(e, "fetch_wait"); cyc++;
        end
        imem_ready = 1'b1; instr_code = ins;
        e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1;
        do_cycle(e, "fetch"); cyc++;
        imem_ready = 1'($urandom);
        e = '0;
        do_cycle(e, "decode"); cyc++;
        if (!is_legal(ins)) begin
            for (int i = 0; i < 20; i++) begin
                imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
                e = '0; e.illegal = 1'b1;
                do_cycle(e, "trap"); cyc++;
            end
            return;
        end
        branch_taken = taken;
        e = exec_model(ins, taken);
        do_cycle(e, "execute"); cyc++;
        exec_seen = last_act;
        branch_taken = 1'($urandom);
        if (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011) begin
            st = (ins[6:0] == 7'b0100011);
            for (int i = 0; i < mw; i++) begin
                dmem_ready = 1'b0; imem_ready = 1'($urandom);
                e = mem_model(st);
                if (abort_mem) begin
                    #2;
                    chk("mem_before_rst", {14'd0, act_s}, {14'd0, e});
                    #1 rst_n = 1'b0;
                    #1;
                    chk("rst_mid_mem_outputs", {14'd0, act_s}, 32'd0);
                    chk("rst_mid_mem_dmem_req", {31'd0, dmem_req}, 32'd0);
                    chk("rst_mid_mem_instret", instret, 32'd0);
                    model_instret = 32'd0;
                    @(negedge clk);
                    return;
                end
                do_cycle(e, "mem_wait"); cyc++;
            end
            dmem_ready = 1'b1;
            e = mem_model(st); e.pc_en = st;
            do_cycle(e, "mem"); cyc++;
            dmem_ready = 1'($urandom);
            if (!st) begin
                e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.pc_en = 1'b1;
                do_cycle(e, "wb"); cyc++;
            end
        end
    endtask

    task automatic do_reset();
        ctl_t e;
        rst_n = 1'b0;
        model_instret = 32'd0;
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'($urandom); dmem_ready = 1'($urandom); branch_taken = 1'($urandom);
            e = '0;
            do_cycle(e, "reset");
        end
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r = $urandom;
        logic [2:0]  bf[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        case ($urandom_range(0, 9))
            0: begin r[6:0] = 7'b0110011; r[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'd0; end
            1: r[6:0] = 7'b0010011;
            2: r[6:0] = 7'b0110111;
            3: r[6:0] = 7'b0010111;
            4: r[6:0] = 7'b1101111;
            5: r[6:0] = 7'b1100111;
            6: begin r[6:0] = 7'b1100011; r[14:12] = bf[$urandom_range(0, 5)]; end
            7: r[6:0] = 7'b0000011;
            8: r[6:0] = 7'b0100011;
            default: r = r;
        endcase
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctl_t        e;
        logic [31:0] ins;
        @(negedge clk);
        do_reset();

        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, ncyc);
        chk("add_latency", ncyc, 32'd3);
        chk("add_alu", {28'd0, exec_seen.alu_ctl}, {28'd0, A_ADD});
        chk("add_instret", instret, 32'd1);

        run_instr(32'h402081B3, 1, 0, 1'b0, 1'b0, ncyc);
        chk("sub_alu", {28'd0, exec_seen.alu_ctl}, {28'd0, A_SUB});

        run_instr(32'h4020D193, 0, 0, 1'b0, 1'b0, ncyc);
        chk("srai_alu", {28'd0, exec_seen.alu_ctl}, {28'd0, A_SRA});
        chk("srai_alusrc_b", {31'd0, exec_seen.alu_b}, 32'd1);

        run_instr(32'h0000A283, 0, 3, 1'b0, 1'b0, ncyc);
        chk("lw_wait_latency", ncyc, 32'd8);
        run_instr(32'h0000A283, 0, 0, 1'b0, 1'b0, ncyc);
        chk("lw_latency", ncyc, 32'd5);

        run_instr(32'h0020A023, 0, 0, 1'b0, 1'b0, ncyc);
        chk("sw_latency", ncyc, 32'd4);

        run_instr(32'h00208463, 0, 0, 1'b1, 1'b0, ncyc);
        chk("beq_taken_pcsrc", {30'd0, exec_seen.pc_src}, 32'd1);
        run_instr(32'h00208463, 0, 0, 1'b0, 1'b0, ncyc);
        chk("beq_not_taken_pcsrc", {30'd0, exec_seen.pc_src}, 32'd0);

        run_instr(32'h000080E7, 0, 0, 1'b0, 1'b0, ncyc);
        chk("jalr_pcsrc", {30'd0, exec_seen.pc_src}, 32'd3);
        chk("jalr_memtoreg", {30'd0, exec_seen.mem_to_reg}, 32'd2);
        chk("instret_after_directed", instret, 32'd9);

        imem_ready = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFF;
        model_instret = 32'hFFFF_FFFF;
        e = '0; e.imem_req = 1'b1;
        do_cycle(e, "forced_wait");
        release dut.instret_q;
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, ncyc);
        chk("instret_wrap", instret, 32'd0);

        run_instr(32'h0020A023, 0, 2, 1'b0, 1'b1, ncyc);
        do_reset();

        for (int n = 0; n < 150; n++) begin
            ins = gen_instr();
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'b0, ncyc);
            if (!is_legal(ins)) do_reset();
        end

        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, ncyc);
        run_instr(32'h00000000, 0, 0, 1'b0, 1'b0, ncyc);
        chk("trap_flag", {31'd0, illegal_instr}, 32'd1);
        chk("trap_imem_req", {31'd0, imem_req}, 32'd0);
        do_reset();
        chk("trap_cleared", {31'd0, illegal_instr}, 32'd0);
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, ncyc);
        chk("post_trap_instret", instret, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
